inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
Write-side counterpart of the instruction memory. It accepts a byte stream from a host or boot interface and assembles big-endian 32-bit instruction words. It writes each word into instruction memory through a single-cycle write strobe at consecutive word addresses. It replaces the hard-coded initial program with a synthesizable load path that runs before the core is released from reset.

Parameters:
SIZE, 32, instruction memory depth in 32-bit words; the loader never writes beyond SIZE-1.
ADDR_W, 32, width of the byte address presented to instruction memory.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset; all state clears on assertion, release is synchronous to clk.
start  input  1  one-cycle pulse; begins a load from word 0.
byte_valid  input  1  byte_in holds a valid byte.
byte_in  input  8  stream byte, most-significant byte of each word first.
byte_ready  output  1  loader accepts a byte this cycle.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  ADDR_W  byte address of the word being written, equal to word index << 2.
wr_data  output  32  assembled instruction word.
busy  output  1  load in progress.
done  output  1  load complete; held high until the next start or reset.
word_count  output  $clog2(SIZE+1)  number of words written so far.

Behaviour:
- Reset (reset=0) values: all outputs 0; FSM in IDLE; assembly register 0; byte index 0.
- FSM states are IDLE, COLLECT, WRITE and DONE.
- IDLE:
  - byte_ready=0.
  - start=1 -> COLLECT; clears word_count and byte index.
- COLLECT:
  - byte_ready=1, busy=1.
  - A byte transfers only when byte_valid and byte_ready are both 1 in the same cycle.
  - On each transfer: assembly <= {assembly[23:0], byte_in}; byte index increments modulo 4.
  - On the 4th transfer -> WRITE.
  - byte_valid gaps of any length are allowed; state is held across them.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=word_count<<2, wr_data=assembled word.
  - byte_ready=0, busy=1.
  - word_count increments at the end of the cycle.
  - If the incremented count equals SIZE -> DONE; otherwise -> COLLECT.
- Latency: wr_en asserts in the cycle immediately after the 4th byte handshake.
- Throughput: at most 1 word per 5 cycles.
- wr_addr and wr_data are registered and hold their last values outside WRITE. Only wr_en qualifies them.
- DONE:
  - done=1, busy=0, byte_ready=0.
  - start=1 -> COLLECT with word_count cleared, i.e. a fresh load.
- start while busy (COLLECT or WRITE) is ignored.
- Bytes offered while byte_ready=0 are not consumed; the source must hold them.
- Reset mid-operation discards any partial word; no wr_en is generated for it. Words already written stay in memory.
- word_count saturates at SIZE; addresses never wrap.

Optional Feature:
Macro: LOADER_END_MARKER_EN.
- Defined: when the 4th byte completes a word equal to 32'hFFFF_FFFF, the FSM goes COLLECT -> DONE directly. The marker word is not written and word_count is unchanged. This allows programs shorter than SIZE.
- Undefined: 32'hFFFF_FFFF is written as an ordinary word; a load ends only when SIZE words have been written.

Test Plan:
1. After reset, pulse start, then send bytes 8C 01 00 04 back-to-back -> one wr_en pulse with wr_addr=0, wr_data=32'h8C010004; word_count=1; busy=1.
2. Send 00 22 50 20, inserting 3 idle cycles between each byte -> wr_addr=4, wr_data=32'h00225020; no early or duplicate wr_en.
3. Use SIZE=4 and send 16 bytes -> 4 writes at addresses 0, 4, 8, 12; then done=1, byte_ready=0, word_count=4; a 17th byte is not accepted.
4. Send 2 bytes, assert reset=0 for 2 cycles, release, pulse start, send 4 bytes AC 05 00 28 -> a single write at wr_addr=0 with wr_data=32'hAC050028; no write from the discarded partial word.
5. Pulse start mid-word during COLLECT -> ignored: byte index and word_count are unchanged, and the next write lands at the expected address.
6. With LOADER_END_MARKER_EN defined, send 1 word followed by FF FF FF FF -> one write, then done=1 with word_count=1. With the macro undefined, the same stream produces a second write of 32'hFFFFFFFF at wr_addr=4.

Source files
------------

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Write side of the instruction memory.
// - Takes a byte stream from a host or boot interface.
// - Packs every four bytes into one big-endian 32-bit word (first byte = MSB).
// - Writes each word with a single-cycle strobe at consecutive word addresses.
// - Runs while the core is still held in reset, in place of a hard-coded
//   initial program.
//
// Configuration macro:
//   LOADER_END_MARKER_EN
//     Defined: a completed word equal to 32'hFFFF_FFFF ends the load without
//     being written, so programs may be shorter than SIZE words.
//     Undefined: that value is written like any other word, and a load ends
//     only after SIZE words.
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,       // asynchronous, active low
    input  logic                        start,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_in,
    output logic                        byte_ready,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(SIZE+1)-1:0]   word_count
);

    localparam int               CNT_W  = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state;
    logic [1:0]     byte_idx;    // bytes already packed into the current word
    logic [31:0]    assembly;    // word being packed, MSB first

    // Helper signals shared by the state machine below.
    logic           handshake;
    logic           last_byte;
    logic [31:0]    next_word;
    logic [CNT_W-1:0] next_count;

    // NOTE: plain continuous assigns for these helpers. Each one is a pure
    // function of registers and inputs, so no storage and no latch can be
    // inferred.
    assign handshake  = byte_valid & byte_ready;
    assign last_byte  = (byte_idx == 2'd3);
    assign next_word  = {assembly[23:0], byte_in};
    assign next_count = word_count + CNT_W'(1);

`ifdef LOADER_END_MARKER_EN
    logic is_marker;
    assign is_marker = (next_word == 32'hFFFF_FFFF);
`endif

    // Loader FSM. Every output is a register and is updated together with the
    // state, so it always matches the state the FSM has just entered.
    // NOTE: all sequential state uses non-blocking assignments. Each register
    // then samples pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            assembly   <= 32'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                // Waiting for the first start pulse after reset.
                IDLE: begin
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                    if (start) begin
                        state      <= COLLECT;
                        byte_idx   <= 2'd0;
                        word_count <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                // Shift accepted bytes into the word. Idle gaps in
                // byte_valid just hold everything, and start is ignored here.
                COLLECT: begin
                    wr_en <= 1'b0;
                    if (handshake) begin
                        assembly <= next_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            byte_ready <= 1'b0;
`ifdef LOADER_END_MARKER_EN
                            if (is_marker) begin
                                // End marker: stop here. The marker is not
                                // written and the count is left as it is.
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state   <= WRITE;
                                wr_en   <= 1'b1;
                                wr_addr <= ADDR_W'(word_count) << 2;
                                wr_data <= next_word;
                            end
`else
                            state   <= WRITE;
                            wr_en   <= 1'b1;
                            wr_addr <= ADDR_W'(word_count) << 2;
                            wr_data <= next_word;
`endif
                        end
                    end
                end

                // One cycle with wr_en high. wr_addr and wr_data keep their
                // values after this cycle; only wr_en marks them as valid.
                WRITE: begin
                    wr_en <= 1'b0;
                    if (word_count != SIZE_C) begin
                        word_count <= next_count;
                    end
                    if (next_count == SIZE_C) begin
                        // The memory is full; no address past SIZE-1 is used.
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        state      <= COLLECT;
                        byte_ready <= 1'b1;
                    end
                end

                // Load finished. done stays high until a new start, which
                // begins a fresh load from word 0.
                DONE: begin
                    wr_en      <= 1'b0;
                    byte_ready <= 1'b0;
                    if (start) begin
                        state      <= COLLECT;
                        byte_idx   <= 2'd0;
                        word_count <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Self-checking bench for inst_mem_loader. It uses SIZE=4 so that a full load
// and the done state come up quickly. Parts:
// - a table of directed words;
// - hand-written sequences for reset, start and the end marker;
// - a random phase checked against a byte-level model of the loader.
// Build with LOADER_END_MARKER_EN defined or undefined; the expected results
// follow the macro.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int SIZE   = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(SIZE + 1);

    logic              clk;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  word_count;

    inst_mem_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t dut_wr[$];   // every write seen on the memory port
    wr_t exp_wr[$];   // writes the model expects

    int checks = 0;
    int errors = 0;

    // Record every write strobe, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) dut_wr.push_back('{wr_addr, wr_data});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Model state: a load is either running or not, plus a count of words
    // written, the done flag and the bytes of the partial word.
    bit          m_active;
    bit          m_done;
    int          m_count;
    logic [7:0]  m_part[$];

    task automatic m_reset();
        m_active = 0; m_done = 0; m_count = 0; m_part.delete();
    endtask

    task automatic m_start();
        if (!m_active) begin
            m_active = 1; m_done = 0; m_count = 0; m_part.delete();
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [31:0] w;
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            w = {m_part[0], m_part[1], m_part[2], m_part[3]};
            m_part.delete();
`ifdef LOADER_END_MARKER_EN
            if (w == 32'hFFFF_FFFF) begin
                m_active = 0; m_done = 1;
                return;
            end
`endif
            exp_wr.push_back('{32'(m_count * 4), w});
            m_count++;
            if (m_count == SIZE) begin
                m_active = 0; m_done = 1;
            end
        end
    endtask

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic do_reset();
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer a byte and hold it until the loader takes it. The wait is bounded.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("byte_handshake_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wr_en"},      64'(wr_en),      64'd0);
        check({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
        check({tag, "_wr_data"},    64'(wr_data),    64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          gap;          // idle cycles between bytes
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          exp_count;
        logic        exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int base;
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

        vecs[0] = '{8'h8C, 8'h01, 8'h00, 8'h04, 0, 32'd0,  32'h8C01_0004, 1, 1'b0};
        vecs[1] = '{8'h00, 8'h22, 8'h50, 8'h20, 3, 32'd4,  32'h0022_5020, 2, 1'b0};
        vecs[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 1, 32'd8,  32'hDEAD_BEEF, 3, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 0, 32'd12, 32'h1234_5678, 4, 1'b1};

        // Outputs while reset is held, then idle after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Full load of SIZE words from the table.
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_byte_ready", 64'(byte_ready), 64'd1);
        base = dut_wr.size();
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].b0);
            repeat (vecs[i].gap) @(negedge clk);
            send_byte(vecs[i].b1);
            repeat (vecs[i].gap) @(negedge clk);
            send_byte(vecs[i].b2);
            repeat (vecs[i].gap) @(negedge clk);
            check($sformatf("v%0d_no_early_write", i), 64'(dut_wr.size()), 64'(base + i));
            send_byte(vecs[i].b3);
            check($sformatf("v%0d_wr_en_latency", i), 64'(wr_en), 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_write_count", i), 64'(dut_wr.size()), 64'(base + i + 1));
            if (dut_wr.size() > 0) begin
                check($sformatf("v%0d_wr_addr", i), 64'(dut_wr[$].addr), 64'(vecs[i].exp_addr));
                check($sformatf("v%0d_wr_data", i), 64'(dut_wr[$].data), 64'(vecs[i].exp_data));
            end
            check($sformatf("v%0d_word_count", i), 64'(word_count), 64'(vecs[i].exp_count));
            check($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(!vecs[i].exp_done));
        end

        // A byte offered after the load is complete must not be taken.
        byte_valid = 1'b1; byte_in = 8'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("full_byte_ready_low", 64'(byte_ready), 64'd0);
        end
        byte_valid = 1'b0;
        check("full_no_extra_write", 64'(dut_wr.size()), 64'(base + 4));
        check("full_word_count", 64'(word_count), 64'd4);
        check("full_done_held", 64'(done), 64'd1);
        check("full_wr_addr_held", 64'(wr_addr), 64'd12);
        check("full_wr_data_held", 64'(wr_data), 64'h1234_5678);

        // Reset in the middle of a word throws the partial word away.
        pulse_start();
        check("restart_count_cleared", 64'(word_count), 64'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        base = dut_wr.size();
        pulse_start();
        send_byte(8'hAC);
        send_byte(8'h05);
        send_byte(8'h00);
        check("after_reset_no_partial_write", 64'(dut_wr.size()), 64'(base));
        send_byte(8'h28);
        @(negedge clk);
        check("after_reset_write_count", 64'(dut_wr.size()), 64'(base + 1));
        if (dut_wr.size() > 0) begin
            check("after_reset_wr_addr", 64'(dut_wr[$].addr), 64'd0);
            check("after_reset_wr_data", 64'(dut_wr[$].data), 64'hAC05_0028);
        end

        // A start pulse in the middle of a word is ignored.
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start();
        check("mid_start_count", 64'(word_count), 64'd1);
        check("mid_start_busy", 64'(busy), 64'd1);
        send_byte(8'h03);
        send_byte(8'h04);
        @(negedge clk);
        check("mid_start_write_count", 64'(dut_wr.size()), 64'(base + 2));
        if (dut_wr.size() > 0) begin
            check("mid_start_wr_addr", 64'(dut_wr[$].addr), 64'd4);
            check("mid_start_wr_data", 64'(dut_wr[$].data), 64'h0102_0304);
        end

        // One word followed by the FF FF FF FF pattern.
        do_reset();
        base = dut_wr.size();
        pulse_start();
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        @(negedge clk);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        @(negedge clk);
`ifdef LOADER_END_MARKER_EN
        check("marker_write_count", 64'(dut_wr.size()), 64'(base + 1));
        check("marker_done", 64'(done), 64'd1);
        check("marker_busy", 64'(busy), 64'd0);
        check("marker_word_count", 64'(word_count), 64'd1);
`else
        check("ff_write_count", 64'(dut_wr.size()), 64'(base + 2));
        if (dut_wr.size() > 0) begin
            check("ff_wr_addr", 64'(dut_wr[$].addr), 64'd4);
            check("ff_wr_data", 64'(dut_wr[$].data), 64'hFFFF_FFFF);
        end
        check("ff_word_count", 64'(word_count), 64'd2);
        check("ff_done", 64'(done), 64'd0);
`endif

        // Random traffic checked against the model.
        do_reset();
        m_reset();
        repeat (2) @(negedge clk);
        dut_wr.delete();
        exp_wr.delete();
        for (int op = 0; op < 400; op++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_start();
                m_start();
            end else if (r == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else if (r == 2 && m_active && m_part.size() == 0) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(8'hFF);
                    m_byte(8'hFF);
                end
                @(negedge clk);
            end else if (m_active) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(b);
                m_byte(b);
                @(negedge clk);
            end else begin
                byte_valid = 1'b1;
                byte_in = 8'($urandom_range(0, 255));
                repeat (3) @(negedge clk);
                byte_valid = 1'b0;
            end
            check($sformatf("rand%0d_word_count", op), 64'(word_count), 64'(m_count));
            check($sformatf("rand%0d_done", op), 64'(done), 64'(m_done));
            check($sformatf("rand%0d_busy", op), 64'(busy), 64'(m_active));
            check($sformatf("rand%0d_byte_ready", op), 64'(byte_ready), 64'(m_active));
        end
        check("rand_total_writes", 64'(dut_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < dut_wr.size(); i++) begin
            check($sformatf("rand_wr%0d_addr", i), 64'(dut_wr[i].addr), 64'(exp_wr[i].addr));
            check($sformatf("rand_wr%0d_data", i), 64'(dut_wr[i].data), 64'(exp_wr[i].data));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
